// File: rtl/rx_pkg.sv
// Shared types and defaults for the serial receive control stage.
package rx_pkg;

  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    SAMPLE    = 3'd2,
    CHECK     = 3'd3,
    LOAD      = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_packet_ctrl_if.sv
// Line, shift-register and consumer signals of the receive control stage.
interface rx_packet_ctrl_if
  import rx_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
);

  logic                 serial_in;
  logic [DATA_BITS:0]   packet_data;
  logic                 data_read;
  logic                 bit_out;
  logic                 shift_strobe;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;

  modport slave (
    input  serial_in, packet_data, data_read,
    output bit_out, shift_strobe, rx_data, data_ready, overrun_error, framing_error
  );

  modport master (
    output serial_in, packet_data, data_read,
    input  bit_out, shift_strobe, rx_data, data_ready, overrun_error, framing_error
  );

endinterface

// File: rtl/rx_bit_timer.sv
// Bit-period counter: clear, load, enable, and a terminal-count flag that
// is programmable per cycle so one counter serves half- and full-bit waits.
module rx_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic [WIDTH-1:0] terminal,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  // Holding at the terminal count keeps the counter from wrapping.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != terminal)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = (count_reg == terminal);

endmodule

// File: rtl/rx_packet_ctrl.sv
// Serial receive control: line synchronizer, start detect, bit timing,
// shift strobes, stop-bit check and the consumer-facing output buffer.
module rx_packet_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic            clk,
  input  logic            n_rst,
  rx_packet_ctrl_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 2);

  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS);

  // [0],[1] synchronize the line; [2] is the previous bit_out for edge detect.
  logic [2:0]           line_reg;
  logic                 bit_sync;
  logic                 start_edge;

  rx_state_e            state_reg, state_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;

  logic                 timer_clear;
  logic                 timer_load;
  logic                 timer_enable;
  logic [CW-1:0]        timer_tc;
  logic                 timer_done;
  logic                 strobe;

  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 data_ready_reg;
  logic                 overrun_reg;
  logic                 framing_reg;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      line_reg <= 3'b111;
    end else begin
      line_reg <= {line_reg[1:0], bus.serial_in};
    end
  end

  assign bit_sync   = line_reg[1];
  assign start_edge = line_reg[2] & ~line_reg[1];

  assign timer_tc     = (state_reg == START_CHK) ? HALF_TC : FULL_TC;
  assign timer_enable = (state_reg == START_CHK) || (state_reg == SAMPLE);
  assign timer_clear  = ((state_reg == IDLE) && start_edge) ||
                        ((state_reg == START_CHK) && timer_done && !bit_sync);
  // Gated by reset so a mid-packet reset never leaks a strobe downstream.
  assign strobe       = n_rst && (state_reg == SAMPLE) && timer_done;
  assign timer_load   = strobe;

  rx_bit_timer #(
    .WIDTH (CW)
  ) u_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (timer_clear),
    .load       (timer_load),
    .load_value ('0),
    .enable     (timer_enable),
    .terminal   (timer_tc),
    .done       (timer_done)
  );

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          state_next = START_CHK;
        end
      end
      START_CHK: begin
        if (timer_done) begin
          if (bit_sync) begin
            state_next = IDLE;
          end else begin
            state_next   = SAMPLE;
            bit_cnt_next = '0;
          end
        end
      end
      SAMPLE: begin
        if (timer_done) begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == LAST_BIT) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        state_next = bus.packet_data[DATA_BITS] ? LOAD : IDLE;
      end
      LOAD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // A load beats a same-cycle read; a read in the load cycle means the old
  // byte was consumed, so no overrun is flagged.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_data_reg    <= '0;
      data_ready_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      framing_reg    <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && start_edge) begin
        framing_reg <= 1'b0;
      end else if ((state_reg == CHECK) && !bus.packet_data[DATA_BITS]) begin
        framing_reg <= 1'b1;
      end

      if (state_reg == LOAD) begin
        rx_data_reg    <= bus.packet_data[DATA_BITS-1:0];
        data_ready_reg <= 1'b1;
        overrun_reg    <= data_ready_reg & ~bus.data_read;
      end else if (bus.data_read) begin
        data_ready_reg <= 1'b0;
        overrun_reg    <= 1'b0;
      end
    end
  end

  assign bus.bit_out       = bit_sync;
  assign bus.shift_strobe  = strobe;
  assign bus.rx_data       = rx_data_reg;
  assign bus.data_ready    = data_ready_reg;
  assign bus.overrun_error = overrun_reg;
  assign bus.framing_error = framing_reg;

endmodule

// File: doc/rx_packet_ctrl.md
# rx_packet_ctrl

Receive control stage for the serial link: synchronizes the raw serial line, detects a start bit, times each bit period, and issues one-cycle shift strobes plus the synchronized bit to the downstream serial-to-parallel shift register. After the last strobe it checks the stop bit in the shift register's parallel output, latches valid data into an output buffer, and reports framing and overrun errors to the consumer.

## Interface
- DATA_BITS, 8: data bits per packet, sent LSB first; the shift register is DATA_BITS+1 wide and shifts LSB first.
- CLKS_PER_BIT, 10: clock cycles per bit period. Must be even and ≥4.
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset, synchronous and active-low.
- serial_in  in  1  raw asynchronous serial line; idle level 1.
- packet_data  in  DATA_BITS+1  shift register parallel output; [DATA_BITS] is the stop bit, [DATA_BITS-1:0] is the data.
- data_read  in  1  consumer pulse acknowledging rx_data.
- bit_out  out  1  synchronized serial line, driven to the shift register serial input.
- shift_strobe  out  1  one-cycle shift enable to the shift register.
- rx_data  out  DATA_BITS  last valid received byte.
- data_ready  out  1  rx_data holds unread data.
- overrun_error  out  1  a valid packet overwrote unread data.
- framing_error  out  1  the last packet had stop bit 0.

## Operation
- Synchronizer: two flops on serial_in, both reset to 1. bit_out is the second flop.
- Edge detect: a third flop holds the previous bit_out. A start edge is prev=1 and bit_out=0.
- FSM states:
  - IDLE: a start edge goes to START_CHK, clears the counter, and clears framing_error.
  - START_CHK: when the counter reaches CLKS_PER_BIT/2-1, sample bit_out. If bit_out=1, the start was false; return to IDLE. Otherwise go to SAMPLE, clearing the counter and the bit count.
  - SAMPLE: when the counter reaches CLKS_PER_BIT-1, assert shift_strobe for one cycle, clear the counter, and increment the bit count. After strobe number DATA_BITS+1, go to CHECK.
  - CHECK: one cycle only; packet_data is now valid. If packet_data[DATA_BITS]=1, go to LOAD. Otherwise set framing_error and go to IDLE.
  - LOAD: rx_data ← packet_data[DATA_BITS-1:0]. If data_ready=1 and data_read=0, set overrun_error. Set data_ready=1, then go to IDLE.
- data_read with no load in the same cycle clears data_ready and overrun_error on the next edge.
- data_read in the same cycle as LOAD: the load wins. data_ready stays 1 and overrun_error is not set.
- A framing error leaves rx_data, data_ready and overrun_error unchanged.
- A start edge seen while in any state other than IDLE is ignored.

## Timing
- Reset values: bit_out=1, shift_strobe=0, rx_data=0, data_ready=0, overrun_error=0, framing_error=0. The FSM is in IDLE and the counters are 0.
- Reset mid-packet: all of the above apply at the first edge with n_rst=0. No strobe is issued in that cycle.
- Synchronizer latency: 2 cycles from a serial_in change to bit_out.
- Start check: CLKS_PER_BIT/2 cycles after the start edge is detected.
- Strobes: each one falls CLKS_PER_BIT cycles after the previous mid-bit point. That is exactly DATA_BITS+1 strobes per packet, spaced CLKS_PER_BIT apart.
- CHECK occurs in the cycle after the final strobe. data_ready rises 2 cycles after the final strobe; framing_error rises 1 cycle after it.
- Counter width is $clog2(CLKS_PER_BIT). Bit count width is $clog2(DATA_BITS+2). Neither wraps in normal operation; both are cleared on each state entry that uses them.
- Back-to-back packets: the FSM is back in IDLE before the stop bit ends, so a start edge arriving immediately after the stop bit is accepted.

## Structure
- Package rx_pkg holds:
  - the FSM state enum typedef (IDLE, START_CHK, SAMPLE, CHECK, LOAD);
  - the default DATA_BITS and CLKS_PER_BIT constants.
- Sub-module rx_bit_timer: a loadable counter with clear, enable, and a programmable terminal-count output. It is used for both the half-bit and the full-bit intervals.
- The synchronizer, edge detect, FSM and output buffer remain in rx_packet_ctrl.

## Test plan
All scenarios use DATA_BITS=8 and CLKS_PER_BIT=10.
- Valid packet 0xA5 with stop bit 1 → 9 strobes 10 cycles apart; packet_data=9'h1A5 in CHECK; rx_data=8'hA5, data_ready=1, both error flags 0.
- Stop bit 0 on 0x3C → framing_error=1 one cycle after the last strobe; data_ready=0; rx_data unchanged.
- Line low for only 3 cycles (glitch) → return to IDLE at the start check; zero strobes; all outputs unchanged.
- Two valid packets 0x11 then 0x22 with no data_read → rx_data=8'h22, overrun_error=1. A data_read pulse then clears data_ready and overrun_error on the next edge.
- n_rst=0 for one cycle during data bit 4 → all outputs at reset values; the FSM is in IDLE. The next packet, 0x7E, is received correctly.
- data_read asserted in the LOAD cycle of a second packet → data_ready stays 1, overrun_error stays 0.
